mult_arbiter: RTL and testbench
===============================

# mult_arbiter

- Round-robin arbiter and controller that shares one shift-add multiplier (Sequencer plus datapath) between `NREQ` requesters.
- Accepts one operand pair at a time from the winning requester and pulses the multiplier's `start`.
- Waits for the multiplier's `ready` to return, then hands the 2n-bit product back to that requester with a one-cycle `done`.
- Sits between client blocks and the multiplier's start/ready control interface.

## Interface
- `n`, 4: operand width; the product is `2*n` bits.
- `NREQ`, 4: number of requesters, at least 1.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with the macro described under Configuration.

- `clock` in 1: single clock; all state changes on its rising edge.
- `nreset` in 1: reset, asynchronous and active-low.
- `req` in NREQ: per-requester request level.
- `a`, `b` in NREQ×n: per-requester operands.
- `gnt` out NREQ: one-hot, one-cycle acceptance pulse.
- `done` out NREQ: one-hot, one-cycle completion pulse.
- `result` out 2n: last product; holds until the next completion.
- `err` out 1: watchdog abort flag, pulses together with `done`.
- `m_start` out 1: start pulse to the multiplier.
- `m_a`, `m_b` out n: operands to the multiplier, held stable from START through WAIT.
- `m_ready` in 1: multiplier ready; high when idle, low while busy.
- `m_product` in 2n: multiplier product, valid when `m_ready` rises.

## Operation
- States are IDLE, START, WAIT and DONE.
- **IDLE**
  - If any `req` bit is high, pick winner `w`: the first set bit at or after `ptr`, scanning upward and wrapping.
  - Latch `w`, capture `a[w]`/`b[w]` into `m_a`/`m_b`, and go to START.
  - With no request, stay in IDLE.
- **START** (exactly one cycle)
  - `gnt[w]=1` and `m_start=1`.
  - Go to WAIT.
  - Clear `m_ready_q` (the sampled copy of `m_ready`) so that a `ready` left high from the previous operation is not mistaken for completion.
- **WAIT**
  - Completion is the rising edge of `m_ready` (current 1, `m_ready_q` 0).
  - On completion, load `result <= m_product` and go to DONE.
  - Any `req` changes during WAIT are ignored.
- **DONE** (exactly one cycle)
  - `done[w]=1`.
  - Set `ptr <= (w+1) mod NREQ`.
  - Go to IDLE.
- **Requester rules**
  - A requester holds `req`, `a` and `b` until it sees `gnt`.
  - Operands are sampled on the IDLE→START edge only.
  - If a requester drops `req` before it is granted, no operation is started for it.
  - If `req` is still high after `done`, it is a new request, arbitrated normally.
- **Priority**
  - The fixed pointer rotation guarantees each active requester is served within `NREQ` operations.
  - With `NREQ`=1 the block degenerates to a pass-through sequencer.
- **Arithmetic**
  - `result` is unsigned and `2n` bits wide, taken verbatim from `m_product`; no truncation.

## Timing
- **Reset values** (asynchronous on `nreset` low, at any point including mid-operation):
  - state IDLE and `ptr`=0.
  - `gnt`, `done`, `err`, `m_start` = 0.
  - `result`, `m_a`, `m_b` = 0.
  - `m_ready_q` = 0.
- Outputs are registered Moore outputs.
- **Cycle sequence**, with a request sampled in IDLE at edge E0:
  - `gnt`/`m_start` are high in the cycle after E0.
  - WAIT begins at E1.
  - `done`/`result` appear one cycle after the edge that samples the `m_ready` rise.
- Overhead beyond the multiplier's own latency is 3 cycles.
- Back-to-back: from DONE the block returns to IDLE, so the next grant comes at the earliest 2 cycles after `done`.
- If `m_ready` is already high during WAIT (no low seen), the block waits for a genuine 0→1 transition.

## Configuration
- Macro `MULT_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in WAIT.
  - If it reaches `TIMEOUT` without completion, go to DONE with `result`=0 and `err`=1 alongside `done[w]`.
  - The pointer advances as on a normal completion.
- **Undefined:**
  - No counter; WAIT is unbounded.
  - `err` is tied 0.

## Structure
- **Package `mult_arb_pkg`:**
  - state enum typedef (IDLE, START, WAIT, DONE).
  - pointer-width function `$clog2(NREQ)`, minimum 1.
  - default `TIMEOUT` constant.
- **Sub-module `rr_picker`:** combinational; takes the `req` vector and `ptr` and returns the winner index and an any-valid flag.
- The FSM, operand registers and watchdog stay in `mult_arbiter`.

## Test plan
- **Single request:** reset, then `req[0]` with a=3, b=5, and a model multiplier that drops ready for 4 cycles → `gnt[0]` plus one `m_start` pulse; `done[0]` with `result`=15; `ptr`=1.
- **Round-robin:** all four `req` held high → grants in order 0,1,2,3,0; each `done` is one-hot and matches its grant.
- **Maximum operands:** a=15, b=15 → `result`=225 with the full 8 bits, no truncation.
- **Stale ready:** `m_ready` stays high for 2 cycles after `m_start`, then low, then high → exactly one `done`, at the true rising edge.
- **Reset mid-operation:** `nreset` pulled low during WAIT → all outputs 0 immediately; a new request after release is granted from `ptr`=0.
- **Watchdog** (macro defined, `TIMEOUT`=8): `m_ready` never rises → `done[w]` and `err` 8 cycles into WAIT, `result`=0, next requester served afterwards.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// The optional watchdog is enabled by the macro MULT_ARBITER_TIMEOUT_EN.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Pointer width: enough bits to index NREQ requesters, never less than one.
  function automatic int unsigned ptr_width(input int unsigned nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner_c,
  output logic            any_c
);

  logic [PW-1:0] idx_c;

  always_comb begin
    winner_c = '0;
    any_c    = 1'b0;
    idx_c    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = PW'((32'(ptr) + i) % NREQ);
      if (!any_c && req[idx_c]) begin
        winner_c = idx_c;
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one start/ready multiplier between NREQ clients.
// Define MULT_ARBITER_TIMEOUT_EN to add a WAIT watchdog that aborts with err.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned n       = 4,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] a,
  input  logic [NREQ*n-1:0] b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*n-1:0]    result,
  output logic              err,
  output logic              m_start,
  output logic [n-1:0]      m_a,
  output logic [n-1:0]      m_b,
  input  logic              m_ready,
  input  logic [2*n-1:0]    m_product
);

  localparam int unsigned PW = ptr_width(NREQ);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]      state, state_d;
  logic [PW-1:0]   ptr, ptr_d, w, w_d, win_c;
  logic            any_c;
  logic [n-1:0]    ma_d, mb_d;
  logic [NREQ-1:0] gnt_d, done_d, w_onehot_c;
  logic [2*n-1:0]  result_d;
  logic            start_d, rdyq_d, m_ready_q;
  logic            low_seen, low_d;
  logic            complete_c, timeout_c;
  logic [n-1:0]    a_arr [NREQ];
  logic [n-1:0]    b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign a_arr[gi] = a[gi*n +: n];
    assign b_arr[gi] = b[gi*n +: n];
  end

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .winner_c (win_c),
    .any_c    (any_c)
  );

  assign w_onehot_c = NREQ'(1) << w;
  // A stale high ready is not a completion: a low must be sampled in WAIT first.
  assign complete_c = m_ready & ~m_ready_q & low_seen;

  // Next-state and registered-output values
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    w_d      = w;
    ma_d     = m_a;
    mb_d     = m_b;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result;
    start_d  = 1'b0;
    rdyq_d   = m_ready_q;
    low_d    = low_seen;
    case (state)
      S_IDLE: begin
        if (any_c) begin
          w_d     = win_c;
          ma_d    = a_arr[win_c];
          mb_d    = b_arr[win_c];
          gnt_d   = NREQ'(1) << win_c;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        rdyq_d  = 1'b0;
        low_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        rdyq_d = m_ready;
        if (!m_ready) low_d = 1'b1;
        if (complete_c) begin
          result_d = m_product;
          done_d   = w_onehot_c;
          state_d  = S_DONE;
        end else if (timeout_c) begin
          result_d = '0;
          done_d   = w_onehot_c;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (w == PW'(NREQ - 1)) ? '0 : w + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      w         <= '0;
      m_a       <= '0;
      m_b       <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      m_start   <= 1'b0;
      m_ready_q <= 1'b0;
      low_seen  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      w         <= w_d;
      m_a       <= ma_d;
      m_b       <= mb_d;
      gnt       <= gnt_d;
      done      <= done_d;
      result    <= result_d;
      m_start   <= start_d;
      m_ready_q <= rdyq_d;
      low_seen  <= low_d;
    end
  end

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  // Watchdog: counts WAIT cycles, expires on the TIMEOUT-th one
  assign timeout_c = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + CW'(1);
      err <= (state == S_WAIT) && !complete_c && timeout_c;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_c      = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier and arbiter model.
module tb_mult_arbiter;

  logic        clock = 1'b0;
  logic        nreset;
  logic [3:0]  req;
  logic [15:0] a, b;
  logic [3:0]  gnt, done;
  logic [7:0]  result;
  logic        err, m_start;
  logic [3:0]  m_a, m_b;
  logic        m_ready;
  logic [7:0]  m_product;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  logic [3:0] av [4];
  logic [3:0] bv [4];

  mult_arbiter #(.n(4), .NREQ(4), .TIMEOUT(8)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .req       (req),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .err       (err),
    .m_start   (m_start),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_ready   (m_ready),
    .m_product (m_product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      a[i*4 +: 4] = av[i];
      b[i*4 +: 4] = bv[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},     32'(gnt),     32'(0));
    chk({tag, "_done"},    32'(done),    32'(0));
    chk({tag, "_err"},     32'(err),     32'(0));
    chk({tag, "_m_start"}, 32'(m_start), 32'(0));
    chk({tag, "_result"},  32'(result),  32'(0));
    chk({tag, "_m_a"},     32'(m_a),     32'(0));
    chk({tag, "_m_b"},     32'(m_b),     32'(0));
  endtask

  // Wait for a grant (bounded) and check it against the model; returns winner.
  task automatic await_grant(output int ew, output bit seen, output int waited);
    ew     = pick(req, ptr_m);
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge clock); #1;
      waited++;
      if (gnt != 4'b0) seen = 1'b1;
    end
    chk("gnt_seen", 32'(seen), 32'(1));
    if (seen) begin
      chk("gnt",     32'(gnt),     32'(1) << ew);
      chk("m_start", 32'(m_start), 32'(1));
      chk("m_a",     32'(m_a),     32'(av[ew]));
      chk("m_b",     32'(m_b),     32'(bv[ew]));
    end
  endtask

  // One full transaction with a multiplier that keeps ready high for `stale`
  // cycles, is busy for `lat` cycles, then raises ready with the product.
  task automatic serve(input int stale, input int lat, input logic [3:0] keep, input bit b2b);
    int ew, waited;
    bit seen;
    logic [7:0] prod;
    await_grant(ew, seen, waited);
    if (!seen) return;
    if (b2b) chk("b2b_gap", 32'(waited), 32'(1));
    prod = 8'(av[ew]) * 8'(bv[ew]);
    if (!keep[ew]) req[ew] = 1'b0;
    @(posedge clock); #1;
    chk("start_pulse", 32'({gnt, m_start}), 32'(0));
    repeat (stale) begin
      @(posedge clock); #1;
      chk("stale_done", 32'(done), 32'(0));
    end
    m_ready = 1'b0;
    repeat (lat) begin
      m_product = 8'($urandom);
      @(posedge clock); #1;
      chk("busy_done", 32'(done), 32'(0));
    end
    m_ready   = 1'b1;
    m_product = prod;
    @(posedge clock); #1;
    chk("done",     32'(done),   32'(1) << ew);
    chk("result",   32'(result), 32'(prod));
    chk("err",      32'(err),    32'(0));
    chk("m_a_hold", 32'(m_a),    32'(av[ew]));
    m_product = 8'($urandom);
    ptr_m = (ew + 1) % 4;
    @(posedge clock); #1;
    chk("done_pulse",  32'(done),   32'(0));
    chk("result_hold", 32'(result), 32'(prod));
  endtask

  initial begin
    int ew, waited;
    bit seen;
    logic [3:0] r;

    nreset = 1'b0; req = '0; a = '0; b = '0; m_ready = 1'b1; m_product = '0;
    for (int i = 0; i < 4; i++) begin av[i] = '0; bv[i] = '0; end
    #12;
    check_reset_outputs("rst");
    @(posedge clock); #1;
    nreset = 1'b1;

    // Single request: 3*5
    av[0] = 4'd3; bv[0] = 4'd5; drive_ops();
    req = 4'b0001;
    serve(0, 4, 4'b0000, 1'b0);

    // Maximum operands, full 8-bit product
    av[1] = 4'd15; bv[1] = 4'd15; drive_ops();
    req = 4'b0010;
    serve(0, 3, 4'b0000, 1'b0);

    // Reset during WAIT, pointer must return to 0
    av[2] = 4'd9; bv[2] = 4'd7; drive_ops();
    req = 4'b0100;
    await_grant(ew, seen, waited);
    req = 4'b0000;
    @(posedge clock); #1;
    m_ready = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_ready = 1'b1;
    @(posedge clock); #1;
    nreset = 1'b1;
    ptr_m = 0;

    // Round-robin with all requests held
    for (int i = 0; i < 4; i++) begin
      av[i] = 4'($urandom); bv[i] = 4'($urandom);
    end
    drive_ops();
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      serve(int'($urandom_range(0, 2)), int'($urandom_range(1, 5)), 4'b1111, i > 0);
    req = 4'b0000;
    repeat (2) @(posedge clock);
    #1;

    // Stale ready for two cycles after start
    av[2] = 4'd6; bv[2] = 4'd11; drive_ops();
    req = 4'b0100;
    serve(2, 3, 4'b0000, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = 4'($urandom); bv[i] = 4'($urandom);
      end
      drive_ops();
      r = 4'($urandom);
      if (r == 4'b0) r = 4'b1000;
      req = r;
      serve(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), 4'($urandom), 1'b0);
    end

`ifdef MULT_ARBITER_TIMEOUT_EN
    // Watchdog: ready never rises, abort 8 cycles into WAIT
    req = 4'b0000;
    @(posedge clock); #1;
    req = 4'b0011;
    await_grant(ew, seen, waited);
    req[ew] = 1'b0;
    @(posedge clock); #1;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (i < 8) chk("wd_early", 32'(done), 32'(0));
    end
    chk("wd_done",   32'(done),   32'(1) << ew);
    chk("wd_err",    32'(err),    32'(1));
    chk("wd_result", 32'(result), 32'(0));
    ptr_m = (ew + 1) % 4;
    m_ready = 1'b1;
    serve(0, 2, 4'b0000, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
